// File: rtl/encoder_16_to_4_seq.sv
// Registered priority encoder with request queuing and a valid/ready output.
// Ports: clk, reset (sync, active-high), enable, in[N_IN], out[OUT_W], valid, ready, pending[N_IN], busy.
module encoder_16_to_4_seq #(
  parameter int N_IN          = 16,
  parameter int OUT_W         = 4,
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_IN-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid,
  input  logic             ready,
  output logic [N_IN-1:0]  pending,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [N_IN-1:0]  pend_q;
  logic [N_IN-1:0]  pend_nxt;
  logic [N_IN-1:0]  clear_mask;
  logic [N_IN-1:0]  set_mask;
  logic [OUT_W-1:0] out_q;
  logic [OUT_W-1:0] out_nxt;
  logic [OUT_W-1:0] win;
  logic             has_req;
  logic             slot_free;
  logic             load;

  // Winner is chosen from registered pending only; the live
  // request vector never competes in the cycle it arrives.
  always_comb begin
    win = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < N_IN; i++) begin
        if (pend_q[i]) win = OUT_W'(i);
      end
    end else begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (pend_q[i]) win = OUT_W'(i);
      end
    end
  end

  assign has_req   = |pend_q;
  assign slot_free = (state == IDLE) | ready;
  assign load      = slot_free & has_req;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = has_req ? HOLD : IDLE;
      HOLD: begin
        if (ready) state_nxt = has_req ? HOLD : IDLE;
        else       state_nxt = HOLD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Set mask is applied after the clear, so a request arriving
  // on the bit being loaded re-arms it for a later emission.
  always_comb begin
    clear_mask = '0;
    if (load) clear_mask = N_IN'(1) << win;
    set_mask = enable ? in : '0;
    out_nxt  = load ? win : out_q;
    pend_nxt = (pend_q & ~clear_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      out_q  <= '0;
    end else begin
      pend_q <= pend_nxt;
      out_q  <= out_nxt;
    end
  end

  assign valid   = (state == HOLD);
  assign out     = out_q;
  assign pending = pend_q;
  assign busy    = has_req | valid;

endmodule
